multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control -- Moore control FSM for a 16-bit multicycle CPU.
//
// Ports
//   clock      in   single clock, rising-edge
//   reset      in   synchronous, active-high
//   instr      in   [15:0] instruction register; opcode = [15:12], funct = [2:0]
//   mem_ready  in   memory handshake; the current access completes when high
//   Zero       in   ALU zero flag, qualifies pc_write in BRANCH
//   IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA
//              out  datapath enables / mux selects
//   ALUSrcB    out  [1:0] 0=regB, 1=const 1, 2=sext(instr[5:0])
//   PCSource   out  [1:0] 0=ALU result, 1=ALUOut reg, 2=jump target
//   ALUControl out  [2:0] ALU operation code
//   pc_write   out  PC load enable
//   state      out  [3:0] current state encoding
//   halted     out  high while parked in HALT
module multicycle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        Zero,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALUControl,
  output logic        pc_write,
  output logic [3:0]  state,
  output logic        halted
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_HALT      = 4'd10;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BNQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;
  localparam logic [3:0] OP_HLT   = 4'b1111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_BNQ = 3'b011;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_op;
  logic [2:0] w_funct;
  logic       w_is_rtype;
  logic       w_funct_ok;
  logic       w_unused;

  assign w_op       = instr[15:12];
  assign w_funct    = instr[2:0];
  assign w_is_rtype = (w_op == OP_RTYPE);
  // 100 and 101 have no ALU meaning; such an R-type becomes a harmless no-op.
  assign w_funct_ok = (w_funct != 3'b100) && (w_funct != 3'b101);
  assign w_unused   = ^instr[11:3];

  assign state  = r_state;
  assign halted = (r_state == S_HALT);

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_op)
          OP_RTYPE, OP_ADDI: w_next = S_EXECUTE;
          OP_LW, OP_SW:      w_next = S_MEM_ADDR;
          OP_BNQ:            w_next = S_BRANCH;
          OP_J:              w_next = S_JUMP;
          OP_HLT:            w_next = S_HALT;
          default:           w_next = S_FETCH;   // unknown opcode = NOP
        endcase
      end
      S_MEM_ADDR: begin
        if (w_op == OP_LW)      w_next = S_MEM_READ;
        else if (w_op == OP_SW) w_next = S_MEM_WRITE;
        else                    w_next = S_FETCH;
      end
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_next = S_ALU_WB;
      S_ALU_WB:    w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_FETCH;               // codes 11-15 recover
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Output decode. IRWrite and pc_write in FETCH are qualified by mem_ready so
  // the IR loads and the PC advances exactly once per completed fetch.
  always_comb begin
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    PCSource   = 2'd0;
    ALUControl = ALU_AND;
    pc_write   = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead    = 1'b1;
        IRWrite    = mem_ready;
        ALUSrcB    = 2'd1;
        ALUControl = ALU_ADD;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Precompute PC + offset for a possible branch.
        ALUSrcB    = 2'd2;
        ALUControl = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        ALUControl = ALU_ADD;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        if (w_is_rtype) begin
          ALUSrcB    = 2'd0;
          ALUControl = w_funct_ok ? w_funct : ALU_AND;
        end else if (w_op == OP_ADDI) begin
          ALUSrcB    = 2'd2;
          ALUControl = ALU_ADD;
        end
      end
      S_ALU_WB: begin
        RegWrite = !(w_is_rtype && !w_funct_ok);
        RegDst   = w_is_rtype;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_BNQ;
        PCSource   = 2'd1;
        pc_write   = Zero;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        pc_write = 1'b1;
      end
      default: ;                                   // HALT and illegal codes: all quiet
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic        Zero;
  logic        IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUControl;
  logic        pc_write;
  logic [3:0]  state;
  logic        halted;

  int total = 0;
  int bad   = 0;
  int zsel  = -1;   // -1: random Zero, else forced value

  multicycle_control dut (
    .clock(clock), .reset(reset), .instr(instr), .mem_ready(mem_ready), .Zero(Zero),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUControl(ALUControl),
    .pc_write(pc_write), .state(state), .halted(halted)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish (obs=timeout exp=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: obs=%h exp=%h (instr=%h t=%0t)", tag, obs, exp, instr, $time);
    end
  endtask

  function automatic logic [16:0] outs();
    return {IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA,
            ALUSrcB, PCSource, ALUControl, pc_write, halted};
  endfunction

  // Expected control word for a named state, straight from the control table.
  function automatic logic [16:0] ref_out(int st, logic [15:0] ins, logic mr, logic z);
    logic ir, mrd, mwr, iord, rw, rd, m2r, asa, pcw, hlt;
    logic [1:0] asb, pcs;
    logic [2:0] alu, fn;
    logic [3:0] op;
    bit rt, ok;
    op = ins[15:12]; fn = ins[2:0];
    rt = (op == 4'd0);
    ok = !(fn == 3'd4 || fn == 3'd5);
    {ir, mrd, mwr, iord, rw, rd, m2r, asa, pcw, hlt} = '0;
    asb = 0; pcs = 0; alu = 0;
    case (st)
      0:  begin mrd = 1; ir = mr; asb = 1; alu = 3'b010; pcw = mr; end
      1:  begin asb = 2; alu = 3'b010; end
      2:  begin asa = 1; asb = 2; alu = 3'b010; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin
            asa = 1;
            if (rt) begin asb = 0; alu = ok ? fn : 3'b000; end
            else if (op == 4'd1) begin asb = 2; alu = 3'b010; end
          end
      7:  begin rw = !(rt && !ok); rd = rt; end
      8:  begin asa = 1; alu = 3'b011; pcs = 1; pcw = z; end
      9:  begin pcs = 2; pcw = 1; end
      10: hlt = 1;
      default: ;
    endcase
    return {ir, mrd, mwr, iord, rw, rd, m2r, asa, asb, pcs, alu, pcw, hlt};
  endfunction

  // One cycle: drive inputs after the falling edge, check, let the next rise act.
  task automatic step(input int st, input logic mr, input logic [15:0] ins);
    @(negedge clock);
    instr     = ins;
    mem_ready = mr;
    Zero      = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
    #1;
    chk("state", 32'(state), 32'(st));
    chk($sformatf("outs_s%0d", st), 32'(outs()), 32'(ref_out(st, ins, mr, Zero)));
    chk("mem_excl", 32'(MemRead & MemWrite), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; mem_ready = 1; Zero = 1;
    @(negedge clock);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd1);
    reset = 0; mem_ready = 0;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Walk one instruction through its expected state sequence.
  task automatic run_instr(input logic [15:0] ins, input int fst, input int mst,
                           input int hlt_n, input bit abort_mem);
    for (int i = 0; i < fst; i++) step(0, 0, ins);
    step(0, 1, ins);
    step(1, rnd(), ins);
    case (ins[15:12])
      4'd0, 4'd1: begin step(6, rnd(), ins); step(7, rnd(), ins); end
      4'd2: begin
        step(2, rnd(), ins);
        for (int i = 0; i < mst; i++) step(3, 0, ins);
        step(3, 1, ins);
        step(4, rnd(), ins);
      end
      4'd3: begin
        step(2, rnd(), ins);
        for (int i = 0; i < mst; i++) step(5, 0, ins);
        if (abort_mem) do_reset();
        else step(5, 1, ins);
      end
      4'd4: step(8, rnd(), ins);
      4'd5: step(9, rnd(), ins);
      4'd15: begin
        for (int i = 0; i < hlt_n; i++) step(10, rnd(), ins);
        do_reset();
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [3:0] ops [11];
    logic [15:0] ins;
    ops = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd14, 4'd15};
    reset = 1; mem_ready = 0; instr = 16'h0000; Zero = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    #1;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_outs", 32'(outs()), 32'(ref_out(0, instr, 1'b0, Zero)));

    // Directed scenarios
    run_instr(16'h0002, 0, 0, 0, 0);   // ADD
    run_instr(16'h2005, 0, 3, 0, 0);   // LW with 3-cycle read stall
    zsel = 1; run_instr(16'h4003, 0, 0, 0, 0);
    zsel = 0; run_instr(16'h4003, 0, 0, 0, 0);
    zsel = -1;
    run_instr(16'h0002, 5, 0, 0, 0);   // 5-cycle fetch stall
    run_instr(16'hF000, 0, 0, 10, 0);  // HLT, held, then reset
    run_instr(16'h3000, 1, 2, 0, 1);   // reset while stalled in MEM_WRITE
    run_instr(16'h0004, 0, 0, 0, 0);   // illegal funct 100
    run_instr(16'h0005, 0, 0, 0, 0);   // illegal funct 101
    run_instr(16'h1007, 0, 0, 0, 0);   // ADDI
    run_instr(16'h5000, 0, 0, 0, 0);   // J
    run_instr(16'h7000, 0, 0, 0, 0);   // NOP opcode

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      ins = 16'($urandom);
      ins[15:12] = ops[$urandom_range(0, 10)];
      run_instr(ins, $urandom_range(0, 3), $urandom_range(1, 4),
                $urandom_range(1, 4), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
